// File: rtl/seq_detect_prog_if.sv
// Bus bundle for seq_detect_prog: config write, serial sample input and match outputs.
// The design drives the slave side; a bit source or bench drives the master side.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               x;
    logic               cnt_clr;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, x, cnt_clr,
        input  y, match_cnt, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, x, cnt_clr,
        output y, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap control,
// valid-gated sampling and a saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0011,
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_prog_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               y_q, y_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               sample;
    logic               cfg_ok;
    logic               hit;

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        y_d    = 1'b0;
        err_d  = 1'b0;

        // A config write owns the cycle: the serial bit is never sampled alongside it.
        sample     = bus.in_valid && !bus.cfg_we;
        cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        hist_shift = {hist_q[MAX_LEN-2:0], bus.x};
        fill_inc   = (fill_q >= len_q) ? len_q : fill_q + 1'b1;

        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        hit = sample && (fill_inc == len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);

        if (bus.cfg_we) begin
            if (cfg_ok) begin
                pat_d  = bus.cfg_pattern;
                len_d  = bus.cfg_len;
                ovl_d  = bus.cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.in_valid) begin
            hist_d = hist_shift;
            // Non-overlap mode forgets the matching bits by emptying the fill count.
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
            y_d    = hit;
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= RST_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: directed scenarios plus random traffic,
// checked against a queue-of-bits reference model.
module tb_seq_detect_prog;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic             y;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    exp_t exp_q[$];

    // Reference model state
    bit           mq[$];
    logic [7:0]   m_pat;
    int           m_len;
    bit           m_ovl;
    int           m_cnt;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) sif ();

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // Drive one cycle of stimulus and push the model's expected response.
    task automatic step(input bit we, input logic [7:0] pat, input int len, input bit ovl,
                        input bit vld, input bit xb, input bit clr, input bit r);
        exp_t e;
        bit   hit;
        @(negedge clk);
        rst             = r;
        sif.cfg_we      = we;
        sif.cfg_pattern = pat;
        sif.cfg_len     = 4'(len);
        sif.cfg_overlap = ovl;
        sif.in_valid    = vld;
        sif.x           = xb;
        sif.cnt_clr     = clr;
        hit   = 1'b0;
        e.err = 1'b0;
        if (r) begin
            mq.delete();
            m_pat = 8'b0000_0011;
            m_len = 4;
            m_ovl = 1'b1;
            m_cnt = 0;
        end else begin
            if (we) begin
                if (len >= 1 && len <= MAX_LEN) begin
                    m_pat = pat;
                    m_len = len;
                    m_ovl = ovl;
                    mq.delete();
                end else begin
                    e.err = 1'b1;
                end
            end else if (vld) begin
                mq.push_back(xb);
                if (mq.size() > m_len) void'(mq.pop_front());
                if (mq.size() == m_len) begin
                    hit = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (mq[i] != m_pat[m_len-1-i]) hit = 1'b0;
                end
                if (hit && !m_ovl) mq.delete();
            end
            if (clr) m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt++;
        end
        e.y   = hit;
        e.cnt = CNT_W'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic sample(input bit xb);
        step(1'b0, 8'h00, 0, 1'b0, 1'b1, xb, 1'b0, 1'b0);
    endtask

    task automatic gap(input bit xb);
        step(1'b0, 8'h00, 0, 1'b0, 1'b0, xb, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [7:0] pat, input int len, input bit ovl);
        step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_cnt();
        step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) sample(bits[i]);
    endtask

    // Absolute counter value expected by the directed scenario.
    task automatic expect_cnt(input string name, input int v);
        @(posedge clk);
        #2;
        chk(name, 32'(sif.match_cnt), 32'(v));
    endtask

    // Monitor: every clock edge produces an output triple to score.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y", 32'(sif.y), 32'(e.y));
                chk("match_cnt", 32'(sif.match_cnt), 32'(e.cnt));
                chk("cfg_err", 32'(sif.cfg_err), 32'(e.err));
            end
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        sif.cfg_we = 1'b0;
        sif.cfg_pattern = '0;
        sif.cfg_len = '0;
        sif.cfg_overlap = 1'b0;
        sif.in_valid = 1'b0;
        sif.x = 1'b0;
        sif.cnt_clr = 1'b0;

        do_rst();
        do_rst();

        // Default 0011 with overlap on a continuous stream
        stream(16'b1100_1101_0011, 12);
        expect_cnt("default_stream_cnt", 2);

        // 101 overlapping, then non-overlapping
        clear_cnt();
        cfg(8'b101, 3, 1'b1);
        stream(16'b101_0101, 7);
        expect_cnt("ovl101_cnt", 3);
        clear_cnt();
        cfg(8'b101, 3, 1'b0);
        stream(16'b101_0101, 7);
        expect_cnt("novl101_cnt", 2);

        // Valid gaps with x toggling in between
        clear_cnt();
        cfg(8'b0011, 4, 1'b1);
        sample(0); gap(1); gap(0);
        sample(0); gap(1);
        sample(1); gap(0); gap(1);
        sample(1); gap(0); gap(0);
        expect_cnt("gap_cnt", 1);

        // Rejected config writes leave detection intact
        clear_cnt();
        cfg(8'hFF, 0, 1'b0);
        cfg(8'hFF, MAX_LEN + 1, 1'b0);
        stream(16'b0011, 4);
        expect_cnt("bad_cfg_cnt", 1);
        sample(0); sample(0); sample(1);
        step(1'b1, 8'hAA, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sample(1);
        expect_cnt("cfg_we_blocks_sample_cnt", 2);

        // Saturation, then clear coincident with a match
        clear_cnt();
        for (int k = 0; k < 5; k++) stream(16'b0011, 4);
        expect_cnt("saturate_cnt", CNT_MAX);
        sample(0); sample(0); sample(1);
        step(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_cnt("clr_wins_cnt", 0);

        // Reset mid-stream discards history
        sample(0); sample(0); sample(1);
        do_rst();
        sample(1);
        stream(16'b0011, 4);
        expect_cnt("rst_midstream_cnt", 1);

        // Random traffic with occasional reconfiguration, clears and resets
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                step(1'b1, 8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                     : $urandom_range(1, 4), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            end else if (r < 5) begin
                step(1'b0, 8'h00, 0, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
            end else if (r < 6) begin
                do_rst();
            end else begin
                step(1'b0, 8'h00, 0, 1'b0, ($urandom_range(0, 4) != 0), 1'($urandom), 1'b0, 1'b0);
            end
        end

        gap(0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
